mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit_pkg.sv | 21 ++
 rtl/mult_div_unit.sv | 143 ++++++++++++++
 tb/tb_mult_div_unit.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - shared encodings and constants for the HI/LO multiply/divide unit
package mult_div_unit_pkg;

  localparam int MD_WIDTH_DEFAULT = 32;
  localparam int MD_LATENCY       = MD_WIDTH_DEFAULT + 2;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PREP  = 2'b01,
    ITER  = 2'b10,
    FIXUP = 2'b11
  } md_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative HI/LO multiply/divide unit, one shift-add/subtract step per cycle
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  md_state_e        state, state_next;
  md_op_e           op_r;
  logic [WIDTH-1:0] a_raw, b_raw, divisor;
  logic             neg_q, neg_r, div_zero;
  // Upper WIDTH+1 bits: partial product / partial remainder; lower WIDTH bits: multiplier / quotient.
  logic [2*WIDTH:0] acc, acc_step;
  logic [CW-1:0]    cnt;

  logic             is_div, is_signed, sign_a, sign_b;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   add_sum, rem_shift, rem_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = PREP;
      PREP:    state_next = ITER;
      ITER:    if (cnt == CW'(WIDTH-1)) state_next = FIXUP;
      FIXUP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    is_div    = (op_r == MD_DIV) || (op_r == MD_DIVU);
    is_signed = (op_r == MD_MULT) || (op_r == MD_DIV);
    sign_a    = is_signed & a_raw[WIDTH-1];
    sign_b    = is_signed & b_raw[WIDTH-1];
    abs_a     = sign_a ? -a_raw : a_raw;
    abs_b     = sign_b ? -b_raw : b_raw;
  end

  // A borrow out of rem_diff means the shifted remainder is below the divisor: restore.
  always_comb begin
    add_sum   = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, divisor} : {(WIDTH+1){1'b0}});
    rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, divisor};
    if (is_div) begin
      if (rem_diff[WIDTH])
        acc_step = {1'b0, rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
        acc_step = {1'b0, rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {1'b0, add_sum, acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod     = acc[2*WIDTH-1:0];
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_r     <= MD_MULT;
      a_raw    <= '0;
      b_raw    <= '0;
      divisor  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r  <= md_op_e'(op);
            a_raw <= operand_a;
            b_raw <= operand_b;
          end else begin
            if (hi_we) hi <= operand_a;
            if (lo_we) lo <= operand_a;
          end
        end
        PREP: begin
          acc      <= {{(WIDTH+1){1'b0}}, abs_a};
          divisor  <= abs_b;
          neg_q    <= sign_a ^ sign_b;
          neg_r    <= sign_a;
          div_zero <= (b_raw == '0);
          cnt      <= '0;
        end
        ITER: begin
          acc <= acc_step;
          cnt <= (cnt == CW'(WIDTH-1)) ? '0 : cnt + 1'b1;
        end
        FIXUP: begin
          done <= 1'b1;
          if (!is_div) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (div_zero) begin
            hi <= a_raw;
            lo <= '1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit against an arithmetic reference model
module tb_mult_div_unit;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;
  localparam int         LAT      = 34;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .hi_we(hi_we), .lo_we(lo_we),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    longint      sa, sb, p;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (mop)
      OP_MULT: begin
        p = sa * sb;
        h = p[63:32];
        l = p[31:0];
      end
      OP_MULTU: begin
        u = {32'b0, a} * {32'b0, b};
        h = u[63:32];
        l = u[31:0];
      end
      OP_DIV: begin
        if (b == 32'd0) begin
          l = 32'hFFFFFFFF; h = a;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          l = 32'h80000000; h = 32'd0;
        end else begin
          p = sa / sb; l = p[31:0];
          p = sa % sb; h = p[31:0];
        end
      end
      default: begin
        if (b == 32'd0) begin
          l = 32'hFFFFFFFF; h = a;
        end else begin
          l = a / b; h = a % b;
        end
      end
    endcase
  endfunction

  // Starts an op at the current negedge and returns at the negedge where done is seen (or the bound).
  // At observation step inj_k a second start (MULTU 2x3) plus hi_we=1 is pulsed for one cycle.
  task automatic run_op(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                        input int inj_k, output int lat, output int busy_cycles, output logic hi_moved);
    logic [31:0] hi_start;
    int k;
    start = 1'b1; op = mop; operand_a = a; operand_b = b; hi_we = 1'b0; lo_we = 1'b0;
    hi_start = hi;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    k = 0; busy_cycles = 0; hi_moved = 1'b0;
    while (!done && k < 60) begin
      if (busy) busy_cycles++;
      if (hi !== hi_start) hi_moved = 1'b1;
      if (k == inj_k) begin
        start = 1'b1; op = OP_MULTU; operand_a = 32'd2; operand_b = 32'd3; hi_we = 1'b1;
      end else begin
        start = 1'b0; hi_we = 1'b0;
      end
      @(posedge clk); @(negedge clk);
      k++;
    end
    start = 1'b0; hi_we = 1'b0;
    lat = k;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h expected 0 0 0 0", busy, done, hi, lo);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [1:0]  ops [5] = '{OP_MULTU, OP_MULT, OP_DIV, OP_DIVU, OP_DIV};
    logic [31:0] as  [5] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd7, 32'h80000000};
    logic [31:0] bs  [5] = '{32'hFFFFFFFF, 32'd7, 32'd2, 32'd0, 32'hFFFFFFFF};
    logic [31:0] ehi [5] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000007, 32'h00000000};
    logic [31:0] elo [5] = '{32'h00000001, 32'hFFFFFFEB, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000};
    int lat, bc;
    logic moved;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], as[i], bs[i], -1, lat, bc, moved);
      checks++;
      if (lat != LAT || bc != LAT) begin
        errors++;
        $display("FAIL directed_latency[%0d]: latency=%0d busy_cycles=%0d expected %0d", i, lat, bc, LAT);
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL directed_busy_at_done[%0d]: busy=%b expected 0", i, busy);
      end
      checks++;
      if (hi !== ehi[i] || lo !== elo[i]) begin
        errors++;
        $display("FAIL directed_result[%0d]: hi=%h lo=%h expected hi=%h lo=%h", i, hi, lo, ehi[i], elo[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_one_cycle: done=%b expected 0", done);
    end
  endtask

  task automatic test_ignore_start;
    int lat, bc;
    logic moved;
    hi_we = 1'b1; operand_a = 32'h0BADF00D;
    @(negedge clk);
    hi_we = 1'b0;
    run_op(OP_DIVU, 32'd100, 32'd7, 7, lat, bc, moved);
    checks++;
    if (moved !== 1'b0) begin
      errors++;
      $display("FAIL hi_held_mid_op: hi changed=%b expected 0", moved);
    end
    checks++;
    if (lat != LAT || hi !== 32'd2 || lo !== 32'd14) begin
      errors++;
      $display("FAIL ignore_start: latency=%0d hi=%h lo=%h expected %0d hi=2 lo=14", lat, hi, lo, LAT);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL no_queued_op: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_mt_write;
    int k;
    hi_we = 1'b1; operand_a = 32'hDEADBEEF;
    @(negedge clk);
    hi_we = 1'b0;
    checks++;
    if (hi !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL mthi: hi=%h expected deadbeef", hi);
    end
    lo_we = 1'b1; operand_a = 32'h00001234;
    @(negedge clk);
    lo_we = 1'b1; hi_we = 1'b1; operand_a = 32'hCAFEF00D;
    @(negedge clk);
    checks++;
    if (hi !== 32'hCAFEF00D || lo !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL mthi_mtlo_both: hi=%h lo=%h expected cafef00d", hi, lo);
    end
    hi_we = 1'b0;
    start = 1'b1; op = OP_MULTU; operand_a = 32'd5; operand_b = 32'd6; lo_we = 1'b1;
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    checks++;
    if (lo !== 32'hCAFEF00D || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_beats_mtlo: lo=%h busy=%b expected cafef00d 1", lo, busy);
    end
    k = 0;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != LAT || hi !== 32'd0 || lo !== 32'd30) begin
      errors++;
      $display("FAIL start_with_mtlo_result: latency=%0d hi=%h lo=%h expected %0d 0 1e", k, hi, lo, LAT);
    end
  endtask

  task automatic test_reset_mid;
    int lat, bc;
    logic moved;
    start = 1'b1; op = OP_MULTU; operand_a = 32'h12345678; operand_b = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_op: busy=%b done=%b hi=%h lo=%h expected 0 0 0 0", busy, done, hi, lo);
    end
    repeat (40) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_discard: done=%b busy=%b expected 0 0", done, busy);
      end
    end
    run_op(OP_MULTU, 32'd1000, 32'd1001, -1, lat, bc, moved);
    checks++;
    if (lat != LAT || hi !== 32'd0 || lo !== 32'd1001000) begin
      errors++;
      $display("FAIL after_reset_op: latency=%0d hi=%h lo=%h expected %0d 0 %h", lat, hi, lo, LAT, 32'd1001000);
    end
  endtask

  task automatic test_random;
    logic [1:0]  mop;
    logic [31:0] a, b, eh, el;
    int lat, bc, sel;
    logic moved;
    for (int i = 0; i < 40; i++) begin
      mop = 2'($urandom_range(0, 3));
      a = $urandom; b = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      else if (sel == 2) begin a = a >> $urandom_range(0, 31); b = b >> $urandom_range(0, 31); end
      model(mop, a, b, eh, el);
      run_op(mop, a, b, -1, lat, bc, moved);
      checks++;
      if (lat != LAT || hi !== eh || lo !== el) begin
        errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: latency=%0d hi=%h lo=%h expected %0d hi=%h lo=%h",
                 i, mop, a, b, lat, hi, lo, LAT, eh, el);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_directed;
    test_ignore_start;
    test_mt_write;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
